// File: rtl/i2c_seq_pkg.sv
// ==== i2c_seq_pkg -- shared states and constants for the I2C register sequencer ====
// ==== rev 1.0 ====
`default_nettype none

package i2c_seq_pkg;

  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;
  localparam logic        RW_WRITE        = 1'b0;
  localparam logic        RW_READ         = 1'b1;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LAUNCH  = 4'd1,
    DEV_W   = 4'd2,
    REG     = 4'd3,
    DATA    = 4'd4,
    RESTART = 4'd5,
    DEV_R   = 4'd6,
    RX      = 4'd7,
    DRAIN   = 4'd8,
    DONE    = 4'd9
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_seq_timer.sv
// ==== i2c_seq_timer -- restartable 16-bit wait-state timer, expires after LIMIT cycles ====
// ==== rev 1.0 ====
`default_nettype none

module i2c_seq_timer #(
  parameter logic [15:0] LIMIT = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expired
);

  logic [15:0] count;

  // clear marks cycle 0 of a new state, so the count resumes at 1 on the next edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd1;
    end else if (!expired) begin
      count <= count + 16'd1;
    end
  end

  assign expired = !clear && (count == (LIMIT - 16'd1));

endmodule

`default_nettype wire

// File: rtl/i2c_reg_sequencer.sv
// ==== i2c_reg_sequencer -- single-register I2C read/write sequencer over a byte-level master ====
// ==== rev 1.0 ====
`default_nettype none

module i2c_reg_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       m_start,
  input  logic       m_ready,
  output logic       m_send,
  output logic [7:0] m_datasend,
  input  logic       m_sended,
  output logic       m_receive,
  input  logic [7:0] m_datareceive,
  input  logic       m_received
);

  seq_state_t state;
  seq_state_t state_q;
  logic       rw;
  logic [6:0] dev;
  logic [7:0] reg_addr;
  logic [7:0] wdata;
  logic [7:0] rx_byte;
  logic       ready_q;
  logic       timer_clear;
  logic       timer_expired;
  logic       waiting;
  logic       early_stop;
  logic       abort;

  assign timer_clear = (state != state_q);
  assign waiting     = state inside {DEV_W, REG, DATA, RESTART, DEV_R, RX, DRAIN};
  // The master only raises m_ready mid-transfer when a NACK made it issue STOP early
  assign early_stop  = (state inside {DEV_W, REG, DATA, RESTART, DEV_R, RX}) && m_ready && !ready_q;
  assign abort       = (waiting && timer_expired) || early_stop;

  i2c_seq_timer #(
    .LIMIT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .expired(timer_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      state_q    <= IDLE;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= 8'h00;
      m_start    <= 1'b0;
      m_send     <= 1'b0;
      m_receive  <= 1'b0;
      m_datasend <= 8'h00;
      rw         <= RW_WRITE;
      dev        <= 7'h00;
      reg_addr   <= 8'h00;
      wdata      <= 8'h00;
      rx_byte    <= 8'h00;
      ready_q    <= 1'b0;
    end else begin
      state_q   <= state;
      ready_q   <= m_ready;
      rsp_valid <= 1'b0;
      if (abort) begin
        state      <= DONE;
        rsp_valid  <= 1'b1;
        rsp_err    <= 1'b1;
        m_start    <= 1'b0;
        m_send     <= 1'b0;
        m_receive  <= 1'b0;
        m_datasend <= 8'h00;
      end else begin
        case (state)
          IDLE: begin
            cmd_ready <= 1'b1;
            if (cmd_valid && cmd_ready && m_ready) begin
              rw         <= cmd_rw;
              dev        <= cmd_dev;
              reg_addr   <= cmd_reg;
              wdata      <= cmd_wdata;
              cmd_ready  <= 1'b0;
              m_start    <= 1'b1;
              m_datasend <= {cmd_dev, 1'b0};
              state      <= LAUNCH;
            end
          end
          LAUNCH: begin
            m_start <= 1'b0;
            m_send  <= 1'b1;
            state   <= DEV_W;
          end
          DEV_W: begin
            if (m_sended) begin
              m_datasend <= reg_addr;
              state      <= REG;
            end
          end
          REG: begin
            if (m_sended) begin
              m_send <= 1'b0;
              if (rw == RW_READ) begin
                m_start    <= 1'b1;
                m_receive  <= 1'b1;
                m_datasend <= {dev, 1'b1};
                state      <= RESTART;
              end else begin
                m_datasend <= wdata;
                state      <= DATA;
              end
            end
          end
          DATA: begin
            if (m_sended) begin
              state <= DRAIN;
            end
          end
          RESTART: begin
            m_start <= 1'b0;
            if (m_sended) begin
              m_receive <= 1'b0;
              state     <= RX;
            end
          end
          RX: begin
            if (m_received) begin
              rx_byte <= m_datareceive;
              state   <= DRAIN;
            end
          end
          DRAIN: begin
            m_send    <= 1'b0;
            m_receive <= 1'b0;
            if (m_ready) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              if (rw == RW_READ) begin
                rsp_rdata <= rx_byte;
              end
            end
          end
          DONE: begin
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/i2c_reg_sequencer.md
I2C_REG_SEQUENCER -- requirements
Module: i2c_reg_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd50000, giving the maximum number of clk cycles spent in any single waiting state.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all flops are posedge clk.
REQ-003 SHALL have port reset, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-004 SHALL have port cmd_valid, input, 1 bit, requesting a command.
REQ-005 SHALL have port cmd_ready, output, 1 bit, high while the sequencer accepts a command.
REQ-006 SHALL have port cmd_rw, input, 1 bit, selecting the operation: 0 write, 1 read.
REQ-007 SHALL have port cmd_dev, input, 7 bits, the 7-bit device address.
REQ-008 SHALL have port cmd_reg, input, 8 bits, the register address.
REQ-009 SHALL have port cmd_wdata, input, 8 bits, the write data.
REQ-010 SHALL have port rsp_valid, output, 1 bit, a one-cycle pulse when a command completes.
REQ-011 SHALL have port rsp_rdata, output, 8 bits, the read data, valid with rsp_valid.
REQ-012 SHALL have port rsp_err, output, 1 bit, the error flag (early stop or timeout), valid with rsp_valid.
REQ-013 SHALL drive the I2C master through: m_start (out, 1), m_ready (in, 1), m_send (out, 1), m_datasend (out, 8), m_sended (in, 1), m_receive (out, 1), m_datareceive (in, 8) and m_received (in, 1).

Function
REQ-014 SHALL hold cmd_ready high only in state IDLE.
REQ-015 SHALL capture all cmd_* fields on cmd_valid&&cmd_ready and leave IDLE on the next cycle, but only when m_ready is high.
REQ-016 SHALL use states IDLE, LAUNCH, DEV_W, REG, DATA, RESTART, DEV_R, RX, DRAIN, DONE.
REQ-017 In LAUNCH, SHALL drive m_start=1 for exactly one cycle with m_datasend={dev,1'b0}, then go to DEV_W.
REQ-018 In DEV_W, SHALL hold m_datasend={dev,0} and m_send=1; on the m_sended pulse, SHALL load m_datasend=reg and go to REG.
REQ-019 In REG for a write, SHALL hold m_send=1; on m_sended, SHALL load m_datasend=wdata and go to DATA.
REQ-020 In REG for a read, on m_sended SHALL pulse m_start for one cycle, drop m_send, load m_datasend={dev,1'b1} and go to RESTART.
REQ-021 In DATA, SHALL drop m_send; on m_sended, SHALL go to DRAIN, so the master issues STOP after ACK.
REQ-022 In RESTART, SHALL wait one m_sended pulse (address+R byte) holding m_receive=1, then go to RX.
REQ-023 In RX, SHALL hold m_receive=0 and capture m_datareceive into rsp_rdata on the m_received pulse, then go to DRAIN.
REQ-024 In DRAIN, SHALL wait for m_ready=1 (STOP finished), then go to DONE.
REQ-025 In DONE, SHALL pulse rsp_valid for one cycle and return to IDLE.
REQ-026 SHALL treat m_ready rising in any state from DEV_W to RX as a NACK-caused early stop: set rsp_err=1 and go to DONE.
REQ-027 SHALL use a timer that restarts on every state change; when it reaches TIMEOUT-1, SHALL set rsp_err=1 and go to DONE with all master outputs low.
REQ-028 When m_sended and m_ready rise in the same cycle, m_ready SHALL take priority (error).
REQ-029 SHALL keep rsp_rdata at its previous value for a write or an errored read, except that a successful read overwrites it.
REQ-030 SHALL drive m_send and m_receive low in IDLE, DRAIN and DONE.
REQ-031 SHALL ignore cmd_valid outside IDLE; no queueing.

Reset
REQ-032 While reset=0 and asynchronously, SHALL force: state=IDLE, cmd_ready=0 until the first clk after release, rsp_valid=0, rsp_err=0, rsp_rdata=8'h00, m_start=0, m_send=0, m_receive=0, m_datasend=8'h00, timer=0.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction without issuing rsp_valid.

Structure
REQ-034 SHALL take the state encoding, TIMEOUT default and the RW_WRITE/RW_READ constants from shared package i2c_seq_pkg.
REQ-035 SHALL contain exactly one sub-module, i2c_seq_timer, a 16-bit restartable counter with a clear input and an expired output.

Verification
REQ-036 Write dev=7'h50, reg=8'h10, wdata=8'hA5 with an ACKing slave model -> bus bytes A0,10,A5 then STOP; rsp_valid=1, rsp_err=0.
REQ-037 Read dev=7'h50, reg=8'h20 with the slave returning 8'h3C -> bus bytes A0,20, RESTART, A1, 3C then STOP; rsp_rdata=8'h3C, rsp_err=0.
REQ-038 Write to absent dev=7'h13 (address NACK; the master returns m_ready=1 after the first byte) -> rsp_err=1, no DATA state entered.
REQ-039 TIMEOUT=16'd100 with m_sended never pulsing -> rsp_valid exactly 100 cycles after entering DEV_W, rsp_err=1, m_send=0.
REQ-040 Reset asserted during RX, then a fresh write -> no rsp_valid from the aborted read; the new write completes with rsp_err=0.
REQ-041 cmd_valid held high continuously -> consecutive commands separated by at least one IDLE cycle; cmd_ready low throughout each transaction.
